score_digit_renderer: RTL and testbench
=======================================

// Module: score_digit_renderer
// PURPOSE
// - Holds the game score as 3-digit BCD and renders it on screen via the numbers glyph ROM.
// - Drives the ROM's digit select and in-glyph pixel index, pipeline-aligned to the ROM's 1-cycle select latency.
// - Gates the returned glyph bit to produce a display-ready pixel for the VGA colour mux.
// - Upstream of numbers; downstream of the VGA sync counters and game logic.
// PARAMETERS
// - X0      default 10'd560  left x of the leftmost digit cell
// - Y0      default 10'd8    top y of the digit row
// - GAP     default 4'd2     blank columns between digit cells (cell pitch = 10+GAP)
// - DIGITS  fixed 3          hundreds, tens, units (not overridable)
// PORTS
// - clock_25         in   1   25 MHz pixel clock
// - reset            in   1   asynchronous, active-high reset
// - h_count          in   10  VGA column, advances by 1 per clock on active lines
// - v_count          in   10  VGA row
// - score_inc        in   1   1-cycle pulse: score +1
// - score_clear      in   1   synchronous clear of score to 000
// - number_pixel     in   1   glyph bit returned by numbers
// - selected_number  out  4   digit code to numbers (0-9 glyph, 10 = blank)
// - number_count     out  8   pixel index 0..99 = row*10+col to numbers
// - digit_pixel      out  1   number_pixel AND window flag, lit score pixel
// - score_bcd        out  12  {hundreds,tens,units} BCD
// - score_max        out  1   high while score_bcd == 12'h999
// BEHAVIOUR
// - Reset (async): score_bcd=0, score_max=0, selected_number=0, number_count=0, window flags=0, column/digit counters=0 -> digit_pixel=0.
// - Score: clear beats inc when both high; inc at 999 saturates (no wrap); units 9->0 carries to tens, tens 9->0 to hundreds.
// - score_bcd updates the edge after inc; display reflects it from the next pixel drawn.
// - Geometry: row = v_count-Y0, valid if 0<=row<=9; x window X0 <= h_count < X0+3*(10+GAP)-GAP.
// - Column tracking: col/digit counters reset at h_count==X0; col counts 0..9+GAP then wraps to 0 and digit++.
// - No divider; cells with col>=10 (gap) are outside the window.
// - Stage 1 (edge E1 after coords): selected_number <= BCD nibble for digit (0=hundreds); win_d1 <= in-window; idx_d1 <= row*10+col ((row<<3)+(row<<1)+col).
// - Stage 2 (E2): numbers latches glyph from selected_number; number_count <= idx_d1; win_d2 <= win_d1.
// - digit_pixel = number_pixel & win_d2 (combinational); total latency 2 clocks from h_count/v_count.
// - Outside window: selected_number holds last value, win flags 0, digit_pixel=0.
// - score change mid-frame: affects only pixels sampled after the update edge (tearing accepted).
// - Reset mid-line: pipeline flushes to 0; rendering resumes cleanly at next h_count==X0.
// CONFIGURATION
// - LEADING_ZERO_BLANK_EN defined: hundreds shows code 10 (blank) when 0; tens shows 10 when hundreds and tens are 0; units always shown ("  7", " 42", "100").
// - Not defined: all three digits always rendered, leading zeros included ("007").
// TESTING
// - Reset asserted mid-line -> all outputs 0 immediately; score_bcd=000 after release.
// - 12 score_inc pulses -> score_bcd=12'h012; add 987 more -> 12'h999, score_max=1; one more inc -> stays 999.
// - score_inc and score_clear same cycle at 12'h345 -> score_bcd=000.
// - Sweep h at v=Y0+3, score=12'h480: digit1 col4 -> selected_number=8, number_count=34 two clocks later.
// - Gap column h=X0+10 -> digit_pixel=0 whatever number_pixel is.
// - Score 007, LEADING_ZERO_BLANK_EN on -> codes 10,10,7; macro off -> codes 0,0,7.

Source files
------------

// File: rtl/score_digit_renderer_if.sv
// Glyph ROM bus between score_digit_renderer (master) and the numbers ROM (slave).
`timescale 1ns/1ps
interface score_digit_renderer_if;
    logic [3:0] selected_number;
    logic [7:0] number_count;
    logic       number_pixel;

    modport master (
        output selected_number,
        output number_count,
        input  number_pixel
    );

    modport slave (
        input  selected_number,
        input  number_count,
        output number_pixel
    );
endinterface

// File: rtl/score_digit_renderer.sv
// 3-digit BCD score counter and on-screen renderer feeding the numbers glyph ROM.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits (glyph code 10).
`timescale 1ns/1ps
module score_digit_renderer #(
    parameter logic [9:0] X0  = 10'd560,
    parameter logic [9:0] Y0  = 10'd8,
    parameter logic [3:0] GAP = 4'd2
) (
    input  logic                          clock_25,
    input  logic                          reset,
    input  logic [9:0]                    h_count,
    input  logic [9:0]                    v_count,
    input  logic                          score_inc,
    input  logic                          score_clear,
    score_digit_renderer_if.master        glyph,
    output logic                          digit_pixel,
    output logic [11:0]                   score_bcd,
    output logic                          score_max
);

    localparam int unsigned Digits  = 3;
    localparam int unsigned Pitch   = 10 + 32'(GAP);
    localparam int unsigned XEndInt = 32'(X0) + Digits * Pitch - 32'(GAP);
    localparam logic [10:0] XEnd    = 11'(XEndInt);
    localparam logic [4:0]  ColLast = 5'(Pitch - 1);

    logic [11:0] score_d;
    logic [4:0]  col_q, col_d, cur_col;
    logic [1:0]  digit_q, digit_d, cur_digit;
    logic        synced_q;
    logic        win_d1, win_d2;
    logic [7:0]  idx_d1;

    logic [9:0]  row;
    logic [7:0]  row8, idx;
    logic        at_x0, x_ok, row_ok, win;
    logic [3:0]  hund_code, tens_code, code;

    assign score_max = (score_bcd == 12'h999);

    // Clear wins over increment; increments stop at 999.
    always_comb begin
        score_d = score_bcd;
        if (score_clear) begin
            score_d = '0;
        end else if (score_inc && !score_max) begin
            if (score_bcd[3:0] != 4'd9) begin
                score_d[3:0] = score_bcd[3:0] + 4'd1;
            end else begin
                score_d[3:0] = 4'd0;
                if (score_bcd[7:4] != 4'd9) begin
                    score_d[7:4] = score_bcd[7:4] + 4'd1;
                end else begin
                    score_d[7:4]  = 4'd0;
                    score_d[11:8] = score_bcd[11:8] + 4'd1;
                end
            end
        end
    end

    assign row    = v_count - Y0;
    assign row_ok = (row <= 10'd9);
    assign at_x0  = (h_count == X0);
    assign x_ok   = (h_count >= X0) && ({1'b0, h_count} < XEnd);

    // Counters are only trusted once aligned at X0, so a mid-line reset stays dark.
    always_comb begin
        cur_col   = at_x0 ? 5'd0 : col_q;
        cur_digit = at_x0 ? 2'd0 : digit_q;
        win       = row_ok && x_ok && (at_x0 || synced_q) && (cur_col < 5'd10);
        if (cur_col == ColLast) begin
            col_d   = 5'd0;
            digit_d = cur_digit + 2'd1;
        end else begin
            col_d   = cur_col + 5'd1;
            digit_d = cur_digit;
        end
    end

    assign row8 = {4'd0, row[3:0]};
    assign idx  = (row8 << 3) + (row8 << 1) + {3'd0, cur_col};

`ifdef LEADING_ZERO_BLANK_EN
    assign hund_code = (score_bcd[11:8] == 4'd0) ? 4'd10 : score_bcd[11:8];
    assign tens_code = (score_bcd[11:4] == 8'd0) ? 4'd10 : score_bcd[7:4];
`else
    assign hund_code = score_bcd[11:8];
    assign tens_code = score_bcd[7:4];
`endif

    always_comb begin
        case (cur_digit)
            2'd0:    code = hund_code;
            2'd1:    code = tens_code;
            default: code = score_bcd[3:0];
        endcase
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            score_bcd             <= '0;
            col_q                 <= '0;
            digit_q               <= '0;
            synced_q              <= 1'b0;
            win_d1                <= 1'b0;
            win_d2                <= 1'b0;
            idx_d1                <= '0;
            glyph.selected_number <= '0;
            glyph.number_count    <= '0;
        end else begin
            score_bcd <= score_d;
            col_q     <= col_d;
            digit_q   <= digit_d;
            synced_q  <= synced_q | at_x0;
            win_d1    <= win;
            if (win) begin
                glyph.selected_number <= code;
                idx_d1                <= idx;
            end
            glyph.number_count <= idx_d1;
            win_d2             <= win_d1;
        end
    end

    assign digit_pixel = glyph.number_pixel & win_d2;

endmodule

// File: tb/tb_score_digit_renderer.sv
// Randomized self-checking bench for score_digit_renderer against an arithmetic reference model.
`timescale 1ns/1ps
module tb_score_digit_renderer;

    localparam int X0 = 560;
    localparam int Y0 = 8;
    localparam int GP = 2;
    localparam int P  = 10 + GP;

    logic       clock_25 = 1'b0;
    logic       reset;
    logic [9:0] h_count, v_count;
    logic       score_inc, score_clear;
    logic       digit_pixel, score_max;
    logic [11:0] score_bcd;

    int total = 0;
    int bad   = 0;

    score_digit_renderer_if gif ();

    score_digit_renderer dut (
        .clock_25    (clock_25),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (v_count),
        .score_inc   (score_inc),
        .score_clear (score_clear),
        .glyph       (gif),
        .digit_pixel (digit_pixel),
        .score_bcd   (score_bcd),
        .score_max   (score_max)
    );

    always #20 clock_25 = ~clock_25;

    function automatic logic [11:0] to_bcd(input int s);
        return {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic int exp_code(input int s, input int d);
        int hu, te, un;
        hu = s / 100;
        te = (s / 10) % 10;
        un = s % 10;
`ifdef LEADING_ZERO_BLANK_EN
        if (d == 0) return (hu == 0) ? 10 : hu;
        if (d == 1) return (hu == 0 && te == 0) ? 10 : te;
`else
        if (d == 0) return hu;
        if (d == 1) return te;
`endif
        return un;
    endfunction

    function automatic bit exp_win(input int h, input int v);
        int dx, r;
        dx = h - X0;
        r  = v - Y0;
        return (r >= 0) && (r <= 9) && (dx >= 0) && (dx < 3 * P) && ((dx % P) < 10);
    endfunction

    function automatic int exp_idx(input int h, input int v);
        return (v - Y0) * 10 + ((h - X0) % P);
    endfunction

    task automatic pulse(input bit inc, input bit clr);
        score_inc   = inc;
        score_clear = clr;
        @(posedge clock_25);
        #1;
        score_inc   = 1'b0;
        score_clear = 1'b0;
    endtask

    task automatic set_score(input int s);
        pulse(1'b0, 1'b1);
        for (int i = 0; i < s; i++) pulse(1'b1, 1'b0);
    endtask

    // Sweeps one line across the digit row; out-of-window pixels get number_pixel=1.
    task automatic sweep_line(input int v, input int s);
        int  prev_h;
        bit  prev_win;
        bit  np;
        h_count = '0;
        v_count = 10'(v);
        gif.number_pixel = 1'b0;
        repeat (3) @(posedge clock_25);
        #1;
        prev_h   = 0;
        prev_win = 1'b0;
        for (int h = X0 - 3; h < X0 + 3 * P + 3; h++) begin
            h_count = 10'(h);
            @(posedge clock_25);
            #1;
            if (exp_win(h, v)) begin
                total++;
                if (gif.selected_number !== 4'(exp_code(s, (h - X0) / P))) begin
                    bad++;
                    $display("FAIL selected_number h=%0d v=%0d s=%0d: got %0d expected %0d",
                             h, v, s, gif.selected_number, exp_code(s, (h - X0) / P));
                end
            end
            if (prev_win) begin
                total++;
                if (gif.number_count !== 8'(exp_idx(prev_h, v))) begin
                    bad++;
                    $display("FAIL number_count h=%0d v=%0d: got %0d expected %0d",
                             prev_h, v, gif.number_count, exp_idx(prev_h, v));
                end
            end
            np = prev_win ? 1'($urandom_range(0, 1)) : 1'b1;
            gif.number_pixel = np;
            #1;
            total++;
            if (digit_pixel !== (np & prev_win)) begin
                bad++;
                $display("FAIL digit_pixel h=%0d v=%0d: got %0b expected %0b",
                         prev_h, v, digit_pixel, np & prev_win);
            end
            prev_h   = h;
            prev_win = exp_win(h, v);
        end
        h_count = '0;
        gif.number_pixel = 1'b0;
    endtask

    task automatic check_score(input string name, input int s);
        total++;
        if (score_bcd !== to_bcd(s) || score_max !== (s == 999)) begin
            bad++;
            $display("FAIL %s: got bcd=%h max=%0b expected bcd=%h max=%0b",
                     name, score_bcd, score_max, to_bcd(s), s == 999);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #50;
        total++;
        if ({gif.selected_number, gif.number_count, digit_pixel, score_bcd, score_max} !== '0) begin
            bad++;
            $display("FAIL reset_state: got sel=%0d cnt=%0d pix=%0b bcd=%h max=%0b expected all 0",
                     gif.selected_number, gif.number_count, digit_pixel, score_bcd, score_max);
        end
        @(posedge clock_25);
        #1;
        reset = 1'b0;
        check_score("reset_release", 0);
    endtask

    task automatic test_reset_mid_line;
        set_score(5);
        v_count = 10'(Y0 + 2);
        gif.number_pixel = 1'b1;
        for (int h = X0 - 3; h < X0 + 16; h++) begin
            h_count = 10'(h);
            @(posedge clock_25);
            #1;
        end
        #4;
        reset = 1'b1;
        #1;
        total++;
        if ({gif.selected_number, gif.number_count, digit_pixel, score_bcd, score_max} !== '0) begin
            bad++;
            $display("FAIL mid_line_reset: got sel=%0d cnt=%0d pix=%0b bcd=%h expected all 0",
                     gif.selected_number, gif.number_count, digit_pixel, score_bcd);
        end
        @(posedge clock_25);
        #1;
        reset = 1'b0;
        check_score("mid_line_release", 0);
        sweep_line(Y0 + 2, 0);
    endtask

    task automatic test_score_count;
        set_score(12);
        check_score("inc_12", 12);
        for (int i = 0; i < 987; i++) pulse(1'b1, 1'b0);
        check_score("inc_999", 999);
        pulse(1'b1, 1'b0);
        check_score("saturate_999", 999);
    endtask

    task automatic test_clear_priority;
        set_score(345);
        check_score("set_345", 345);
        pulse(1'b1, 1'b1);
        check_score("clear_beats_inc", 0);
    endtask

    task automatic test_random_score;
        int s;
        bit inc, clr;
        set_score(990);
        s = 990;
        for (int i = 0; i < 300; i++) begin
            inc = 1'($urandom_range(0, 9) != 0);
            clr = 1'($urandom_range(0, 40) == 0);
            pulse(inc, clr);
            if (clr) s = 0;
            else if (inc && s < 999) s++;
            check_score("random_score", s);
        end
    endtask

    task automatic test_sweep_480;
        set_score(480);
        sweep_line(Y0 + 3, 480);
    endtask

    task automatic test_leading_zero;
        set_score(7);
        sweep_line(Y0 + 5, 7);
        set_score(42);
        sweep_line(Y0, 42);
    endtask

    task automatic test_random_sweep;
        int s, v;
        for (int i = 0; i < 5; i++) begin
            s = $urandom_range(0, 999);
            v = Y0 - 1 + $urandom_range(0, 11);
            set_score(s);
            sweep_line(v, s);
        end
    endtask

    initial begin
        h_count = '0;
        v_count = '0;
        score_inc = 1'b0;
        score_clear = 1'b0;
        gif.number_pixel = 1'b0;
        test_reset;
        test_score_count;
        test_clear_priority;
        test_random_score;
        test_sweep_480;
        test_leading_zero;
        test_reset_mid_line;
        test_random_sweep;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
